ayatsuki_bus_fabric: RTL

Parametrised single-master, N-slave bus fabric for the AyaTsuki SoC. It replaces the hard-wired timer/UART/memory read-data decode in the SoC top. It routes the core's split read/write bus to up to 8 memory-mapped slaves using per-slave base/mask windows. It adds per-slave read wait states, a read timeout, decode-error reporting and a saturating error counter.

---
 rtl/ayatsuki_bus_fabric.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ayatsuki_bus_fabric.sv
// Single-master, N-slave bus fabric: base/mask address decode, read FSM with
// per-slave wait states and timeout, posted writes and a saturating error counter.
module ayatsuki_bus_fabric #(
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h0000_2000, 32'h0000_1010, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F000},
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_r_en_i,
    input  logic [ADDR_W-1:0]       m_r_addr_i,
    output logic [DATA_W-1:0]       m_r_data_o,
    output logic                    m_r_valid_o,
    output logic                    m_err_o,
    output logic                    m_stall_o,
    input  logic                    m_w_en_i,
    input  logic [ADDR_W-1:0]       m_w_addr_i,
    input  logic [DATA_W-1:0]       m_w_data_i,
    output logic [N_SLV-1:0]        s_r_en_o,
    output logic [ADDR_W-1:0]       s_r_addr_o,
    input  logic [N_SLV*DATA_W-1:0] s_r_data_i,
    input  logic [N_SLV-1:0]        s_r_ready_i,
    output logic [N_SLV-1:0]        s_w_en_o,
    output logic [ADDR_W-1:0]       s_w_addr_o,
    output logic [DATA_W-1:0]       s_w_data_o,
    output logic [7:0]              err_cnt_o
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // Timeout fires in the cycle the counter shows TIMEOUT-1, i.e. TIMEOUT cycles after the request.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Returns {hit, idx}; iterating downwards lets the lowest matching index win.
    function automatic logic [3:0] decode(input logic [ADDR_W-1:0] addr);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                r = {1'b1, 3'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [N_SLV-1:0] onehot(input logic [2:0] idx);
        logic [N_SLV-1:0] r;
        for (int i = 0; i < N_SLV; i++) begin
            r[i] = (idx == 3'(i));
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          idx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          cnt_r;
    logic                miss_r;
    logic [7:0]          err_cnt_r;

    logic [3:0]          rd_dec_s;
    logic [3:0]          wr_dec_s;
    logic                rd_hit_s;
    logic [2:0]          rd_idx_s;
    logic                wr_hit_s;
    logic                ready_sel_s;
    logic [DATA_W-1:0]   rdata_sel_s;
    logic                rd_wait_s;
    logic                timeout_s;
    logic                done_s;
    logic                accept_s;
    logic                rd_miss_s;
    logic                wr_miss_s;
    logic [8:0]          err_sum_s;

    assign rd_dec_s  = decode(m_r_addr_i);
    assign wr_dec_s  = decode(m_w_addr_i);
    assign rd_hit_s  = rd_dec_s[3];
    assign rd_idx_s  = rd_dec_s[2:0];
    assign wr_hit_s  = wr_dec_s[3];

    // Select ready and data of the slave currently being read.
    always_comb begin
        ready_sel_s = 1'b0;
        rdata_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_r == 3'(i)) begin
                ready_sel_s = s_r_ready_i[i];
                rdata_sel_s = s_r_data_i[i*DATA_W +: DATA_W];
            end else begin
                ready_sel_s = ready_sel_s;
                rdata_sel_s = rdata_sel_s;
            end
        end
    end

    assign rd_wait_s = (state_r == RD_WAIT);
    assign timeout_s = rd_wait_s && !ready_sel_s && (cnt_r == TO_LAST);
    assign done_s    = rd_wait_s && (ready_sel_s || (cnt_r == TO_LAST));
    // A new request is taken in IDLE or in the completing wait cycle (no bubble).
    assign accept_s  = m_r_en_i && (!rd_wait_s || done_s);
    assign rd_miss_s = accept_s && !rd_hit_s;
    assign wr_miss_s = m_w_en_i && !wr_hit_s;
    assign err_sum_s = {1'b0, err_cnt_r} + 9'(rd_miss_s) + 9'(wr_miss_s) + 9'(timeout_s);

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && rd_hit_s) begin
                    state_next_s = RD_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (done_s) begin
                    state_next_s = (accept_s && rd_hit_s) ? RD_WAIT : IDLE;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Read FSM outputs; the miss response comes from a register, the rest is combinational.
    always_comb begin
        m_r_valid_o = miss_r;
        m_err_o     = miss_r;
        m_r_data_o  = {DATA_W{1'b0}};
        m_stall_o   = 1'b0;
        s_r_en_o    = {N_SLV{1'b0}};
        s_r_addr_o  = m_r_addr_i;
        case (state_r)
            IDLE: begin
                if (accept_s && rd_hit_s) begin
                    s_r_en_o = onehot(rd_idx_s);
                end else begin
                    s_r_en_o = {N_SLV{1'b0}};
                end
            end
            RD_WAIT: begin
                if (ready_sel_s) begin
                    m_r_valid_o = 1'b1;
                    m_r_data_o  = rdata_sel_s;
                end else if (timeout_s) begin
                    m_r_valid_o = 1'b1;
                    m_err_o     = 1'b1;
                end else begin
                    m_stall_o   = 1'b1;
                end
                if (accept_s && rd_hit_s) begin
                    s_r_en_o   = onehot(rd_idx_s);
                    s_r_addr_o = m_r_addr_i;
                end else if (timeout_s) begin
                    s_r_en_o   = {N_SLV{1'b0}};
                    s_r_addr_o = addr_r;
                end else begin
                    s_r_en_o   = onehot(idx_r);
                    s_r_addr_o = addr_r;
                end
            end
            default: begin
                s_r_en_o = {N_SLV{1'b0}};
            end
        endcase
    end

    // Latched read target, wait counter and registered miss response.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r  <= 3'd0;
            addr_r <= {ADDR_W{1'b0}};
            cnt_r  <= 8'd0;
            miss_r <= 1'b0;
        end else begin
            miss_r <= rd_miss_s;
            if (accept_s && rd_hit_s) begin
                idx_r  <= rd_idx_s;
                addr_r <= m_r_addr_i;
                cnt_r  <= 8'd0;
            end else if (rd_wait_s) begin
                cnt_r  <= cnt_r + 8'd1;
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end

    // Saturating error counter; coincident events add together.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
        end
    end

    assign err_cnt_o  = err_cnt_r;
    assign s_w_en_o   = (m_w_en_i && wr_hit_s) ? onehot(wr_dec_s[2:0]) : {N_SLV{1'b0}};
    assign s_w_addr_o = m_w_addr_i;
    assign s_w_data_o = m_w_data_i;

endmodule
